// File: rtl/sid_reg_if.sv
// -----------------------------------------------------------------------------
// sid_reg_if -- CPU bus front end and register file of a SID-style sound chip.
//
// Captures CPU reads/writes on the rising edge of phi2 (with cs_n low), holds
// the voice/filter write-only registers and returns the read-only sources.
// A bus latch remembers the last value seen on the data bus; reads of
// write-only addresses return that latch.
//
// Optional feature (macro SID_BUS_DECAY_EN): when defined, the bus latch
// clears to 0x00 after DECAY_CYCLES clk cycles with no access. When the
// macro is undefined the latch holds indefinitely.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   phi2, cs_n, rw        CPU bus phase, chip select (low), 1=read/0=write
//   addr[4:0], data_in    register address and write data
//   potx, poty            read-only paddle values (0x19, 0x1A)
//   osc3_in, env3_in      read-only voice-3 oscillator / envelope (0x1B, 0x1C)
//   data_out, data_oe     read data and read-drive enable
//   freq0..2, pw0..2      voice frequency words / pulse widths
//   ctrl0..2, ad0..2, sr0..2  voice control, attack/decay, sustain/release
//   fc, res_filt, mode_vol    filter cutoff, resonance/routing, mode/volume
//   wr_strobe, wr_addr    one-cycle pulse and address of every accepted write
//
// Bus access semantics: an access is taken on the single clk cycle where phi2
// is high, was low on the previous cycle, cs_n is low, and phi2 has been seen
// low since the last reset. Nothing else on the bus has any effect; holding
// phi2 high never retriggers, and data_oe follows phi2/cs_n with one cycle of
// register delay after a read has been taken.
// -----------------------------------------------------------------------------
module sid_reg_if #(
    parameter logic [15:0] DECAY_CYCLES = 16'd8000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        phi2,
    input  logic        cs_n,
    input  logic        rw,
    input  logic [4:0]  addr,
    input  logic [7:0]  data_in,
    input  logic [7:0]  potx,
    input  logic [7:0]  poty,
    input  logic [7:0]  osc3_in,
    input  logic [7:0]  env3_in,
    output logic [7:0]  data_out,
    output logic        data_oe,
    output logic [15:0] freq0,
    output logic [15:0] freq1,
    output logic [15:0] freq2,
    output logic [11:0] pw0,
    output logic [11:0] pw1,
    output logic [11:0] pw2,
    output logic [7:0]  ctrl0,
    output logic [7:0]  ctrl1,
    output logic [7:0]  ctrl2,
    output logic [7:0]  ad0,
    output logic [7:0]  ad1,
    output logic [7:0]  ad2,
    output logic [7:0]  sr0,
    output logic [7:0]  sr1,
    output logic [7:0]  sr2,
    output logic [10:0] fc,
    output logic [7:0]  res_filt,
    output logic [7:0]  mode_vol,
    output logic        wr_strobe,
    output logic [4:0]  wr_addr
);

    logic [15:0] freq_r [3];
    logic [11:0] pw_r   [3];
    logic [7:0]  ctrl_r [3];
    logic [7:0]  ad_r   [3];
    logic [7:0]  sr_r   [3];
    logic [10:0] fc_r;
    logic [7:0]  res_filt_r;
    logic [7:0]  mode_vol_r;
    logic [7:0]  bus_latch;

    logic phi2_q;
    // Cleared by a reset taken while phi2 is high so that the still-high phi2
    // cannot look like a fresh rising edge once reset is released.
    logic armed;

    logic acc_edge;
    logic wr_edge;
    logic rd_edge;
    logic [7:0] rd_val;
    logic decay_hit;

    assign acc_edge = phi2 & ~phi2_q & armed & ~cs_n;
    assign wr_edge  = acc_edge & ~rw;
    assign rd_edge  = acc_edge &  rw;

    always_comb begin
        rd_val = bus_latch;
        case (addr)
            5'h19:   rd_val = potx;
            5'h1A:   rd_val = poty;
            5'h1B:   rd_val = osc3_in;
            5'h1C:   rd_val = env3_in;
            default: rd_val = bus_latch;
        endcase
    end

`ifdef SID_BUS_DECAY_EN
    // Saturating idle counter; restarts on every access edge.
    logic [15:0] decay_cnt;

    assign decay_hit = ({1'b0, decay_cnt} + 17'd1) >= {1'b0, DECAY_CYCLES};

    always_ff @(posedge clk) begin
        if (rst) begin
            decay_cnt <= 16'd0;
        end else if (acc_edge) begin
            decay_cnt <= 16'd0;
        end else if (decay_cnt != 16'hFFFF) begin
            decay_cnt <= decay_cnt + 16'd1;
        end
    end
`else
    assign decay_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int v = 0; v < 3; v++) begin
                freq_r[v] <= 16'd0;
                pw_r[v]   <= 12'd0;
                ctrl_r[v] <= 8'd0;
                ad_r[v]   <= 8'd0;
                sr_r[v]   <= 8'd0;
            end
            fc_r       <= 11'd0;
            res_filt_r <= 8'd0;
            mode_vol_r <= 8'd0;
            bus_latch  <= 8'd0;
            data_out   <= 8'd0;
            data_oe    <= 1'b0;
            wr_strobe  <= 1'b0;
            wr_addr    <= 5'd0;
            phi2_q     <= 1'b0;
            armed      <= ~phi2;
        end else begin
            phi2_q    <= phi2;
            armed     <= armed | ~phi2;
            wr_strobe <= 1'b0;

            if (wr_edge) begin
                wr_strobe <= 1'b1;
                wr_addr   <= addr;
                bus_latch <= data_in;
                data_oe   <= 1'b0;
                // Voice v occupies addresses 7*v .. 7*v+6.
                for (int v = 0; v < 3; v++) begin
                    if (addr == 5'(7 * v + 0)) freq_r[v][7:0]  <= data_in;
                    if (addr == 5'(7 * v + 1)) freq_r[v][15:8] <= data_in;
                    if (addr == 5'(7 * v + 2)) pw_r[v][7:0]    <= data_in;
                    if (addr == 5'(7 * v + 3)) pw_r[v][11:8]   <= data_in[3:0];
                    if (addr == 5'(7 * v + 4)) ctrl_r[v]       <= data_in;
                    if (addr == 5'(7 * v + 5)) ad_r[v]         <= data_in;
                    if (addr == 5'(7 * v + 6)) sr_r[v]         <= data_in;
                end
                case (addr)
                    5'h15:   fc_r[2:0]  <= data_in[2:0];
                    5'h16:   fc_r[10:3] <= data_in;
                    5'h17:   res_filt_r <= data_in;
                    5'h18:   mode_vol_r <= data_in;
                    default: ;
                endcase
            end else if (rd_edge) begin
                data_out  <= rd_val;
                bus_latch <= rd_val;
                data_oe   <= 1'b1;
            end else begin
                // Keep driving only while the read cycle is still in progress.
                data_oe <= data_oe & phi2 & ~cs_n;
                if (decay_hit) bus_latch <= 8'd0;
            end
        end
    end

    assign freq0    = freq_r[0];
    assign freq1    = freq_r[1];
    assign freq2    = freq_r[2];
    assign pw0      = pw_r[0];
    assign pw1      = pw_r[1];
    assign pw2      = pw_r[2];
    assign ctrl0    = ctrl_r[0];
    assign ctrl1    = ctrl_r[1];
    assign ctrl2    = ctrl_r[2];
    assign ad0      = ad_r[0];
    assign ad1      = ad_r[1];
    assign ad2      = ad_r[2];
    assign sr0      = sr_r[0];
    assign sr1      = sr_r[1];
    assign sr2      = sr_r[2];
    assign fc       = fc_r;
    assign res_filt = res_filt_r;
    assign mode_vol = mode_vol_r;

endmodule

// File: doc/sid_reg_if.md
SID_REG_IF -- requirements
Module: sid_reg_if

Interface
REQ-001 Parameter: DECAY_CYCLES, 16'd8000, idle clk cycles before the latched bus value clears (used only with SID_BUS_DECAY_EN).
REQ-002 clk  input  1  system clock, all logic on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 phi2  input  1  CPU bus phase, synchronous to clk; an access starts on its rising edge.
REQ-005 cs_n  input  1  chip select, active low.
REQ-006 rw  input  1  1 = read, 0 = write.
REQ-007 addr  input  5  register address 0x00-0x1F.
REQ-008 data_in  input  8  CPU write data.
REQ-009 potx, poty, osc3_in, env3_in  input  8 each  read-only sources (osc3_in = voice-3 oscillator upper 8 bits).
REQ-010 data_out  output  8  read data; data_oe  output  1  read-drive enable.
REQ-011 freq0..freq2  output  16  voice frequency words; pw0..pw2  output  12  voice pulse widths.
REQ-012 ctrl0..2, ad0..2, sr0..2  output  8 each  voice control, attack/decay, sustain/release.
REQ-013 fc  output  11; res_filt  output  8; mode_vol  output  8  filter/volume registers.
REQ-014 wr_strobe  output  1  one-cycle pulse on every accepted write; wr_addr  output  5  address of that write.

Function
REQ-015 Internal phi2_q = phi2 registered; access edge = phi2 & ~phi2_q & ~cs_n; only access edges act on the bus.
REQ-016 Write (rw=0) at access edge: target register updated on that clk edge; new value visible on outputs next cycle; wr_strobe=1 and wr_addr=addr for exactly that one cycle.
REQ-017 Map per voice v (base 7*v): +0 freq[7:0], +1 freq[15:8], +2 pw[7:0], +3 pw[11:8] from data_in[3:0] (data_in[7:4] discarded), +4 ctrl, +5 ad, +6 sr.
REQ-018 0x15 fc[2:0] from data_in[2:0]; 0x16 fc[10:3]; 0x17 res_filt; 0x18 mode_vol.
REQ-019 Writes to 0x19-0x1F change no output register but still pulse wr_strobe and update the bus latch.
REQ-020 Read (rw=1) at access edge: data_out loaded on that edge: 0x19 potx, 0x1A poty, 0x1B osc3_in, 0x1C env3_in, all other addresses the bus latch value.
REQ-021 data_oe =1 from the cycle after a read access edge while phi2=1 and cs_n=0; drops the cycle after phi2 or cs_n deasserts; 0 for writes.
REQ-022 Bus latch: loaded with data_in on every write and with the returned data_out on every read.
REQ-023 Access edge with cs_n=1: no state change, no strobe; phi2 held high does not retrigger.
REQ-024 Back-to-back accesses on consecutive phi2 pulses are each handled independently; no access is dropped.
REQ-025 Partial writes: writing one byte of freq/pw/fc leaves the other byte unchanged; no double-buffering.

Reset
REQ-026 rst=1 at a clk edge: all register outputs, data_out, bus latch, decay counter, phi2_q cleared to 0; data_oe=0, wr_strobe=0.
REQ-027 rst mid-access aborts it: no write applied that cycle; next access requires a new phi2 rising edge after rst falls.

Configuration
REQ-028 Macro SID_BUS_DECAY_EN defined: 16-bit counter reset on every access edge, increments otherwise, saturates; when it reaches DECAY_CYCLES the bus latch clears to 0x00.
REQ-029 SID_BUS_DECAY_EN undefined: no counter; bus latch holds its value indefinitely until next access or reset.

Verification
REQ-030 Write 0x00=0x34, 0x01=0x12 -> freq0=0x1234 next cycle; two wr_strobe pulses, wr_addr 0x00 then 0x01.
REQ-031 Write 0x0A=0xAB (voice1 pw hi) -> pw1[11:8]=0xB, pw1[7:0] unchanged; read 0x0A -> data_out=0xAB (bus latch).
REQ-032 osc3_in=0x5A, read 0x1B -> data_out=0x5A, data_oe high from next cycle until phi2 falls, then 0.
REQ-033 With SID_BUS_DECAY_EN, DECAY_CYCLES=16: write 0x04=0x41, idle 16 cycles, read 0x04 -> 0x00; read at 10 idle cycles -> 0x41; without macro -> 0x41 after 100 cycles.
REQ-034 cs_n=1 during phi2 pulse with write 0x18=0xFF -> mode_vol stays 0, no wr_strobe.
REQ-035 rst asserted on the access edge of write 0x05=0x99 -> ad0=0 after reset, no wr_strobe; phi2 held high afterward triggers nothing.
